// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen
//   Parametrised Fibonacci LFSR random source for game logic (serve angle,
//   serve direction, AI jitter). Each request runs the LFSR STEPS times to
//   decorrelate consecutive outputs. The result is then range-reduced to
//   [0, range_max] by repeated subtraction.
//
// Parameters
//   WIDTH  LFSR state width (>= 3)
//   TAPS   feedback mask; feedback bit = XOR of state bits selected by TAPS
//   SEED   reset state and substitute for an all-zero seed (nonzero)
//   STEPS  LFSR shifts per generated value (>= 1)
//   OUT_W  output width (<= WIDTH)
//
// Ports
//   clock      system clock
//   reset      asynchronous, active-high
//   enable     free-run shifting while idle (player timing adds entropy)
//   seed_load  load seed_in into the LFSR, abort any request (top priority)
//   seed_in    seed value
//   req        request one value (accepted only while idle)
//   range_max  inclusive upper bound of the result; 0 selects full range
//   busy       high between accept and the valid cycle, exclusive of both
//   valid      one-cycle pulse; rnd updates in the same cycle
//   rnd        last generated value, held until the next valid

module lfsr_rand_gen #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1),
  parameter int unsigned       STEPS = 16,
  parameter int unsigned       OUT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] range_max,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rnd
);

  localparam int unsigned CNT_W = (STEPS < 2) ? 1 : $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_REDUCE
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] state_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic [OUT_W-1:0] range_q, range_d;
  logic [OUT_W-1:0] range_inc;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // One LFSR shift: feedback enters at bit 0.
  assign state_nxt = {state_q[WIDTH-2:0], ^(state_q & TAPS)};

  // Wraps to 0 only when range_q is all ones, and then every value is
  // already in range, so the subtraction below is never taken.
  assign range_inc = range_q + OUT_W'(1);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    count_d = count_q;
    value_d = value_q;
    range_d = range_q;
    rnd_d   = rnd_q;
    valid_d = 1'b0;

    if (seed_load) begin
      // Zero-lockup guard: an all-zero LFSR would never leave zero.
      state_d = (seed_in == '0) ? SEED : seed_in;
      fsm_d   = S_IDLE;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (enable) begin
            state_d = state_nxt;
          end
          if (req) begin
            range_d = range_max;
            count_d = '0;
            fsm_d   = S_SHIFT;
          end
        end

        S_SHIFT: begin
          state_d = state_nxt;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_STEP) begin
            value_d = state_nxt[OUT_W-1:0];
            fsm_d   = S_REDUCE;
          end
        end

        S_REDUCE: begin
          if ((range_q == '0) || (value_q <= range_q)) begin
            rnd_d   = value_q;
            valid_d = 1'b1;
            fsm_d   = S_IDLE;
          end else begin
            value_d = value_q - range_inc;
          end
        end

        default: begin
          fsm_d = S_IDLE;
        end
      endcase
    end

    // Registered busy follows the next FSM state, so it rises the cycle after
    // accept and is already low in the valid cycle.
    busy_d = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      state_q <= SEED;
      count_q <= '0;
      value_q <= '0;
      range_q <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      count_q <= count_d;
      value_q <= value_d;
      range_q <= range_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign rnd   = rnd_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Testbench for lfsr_rand_gen: a 4-bit single-step instance for exact sequence
// checks and a default instance for range reduction, seeding and reset cases.
module tb_lfsr_rand_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Small instance: WIDTH=4, TAPS=4'hC, SEED=1, STEPS=1, OUT_W=4
  logic       s_reset, s_enable, s_seed_load, s_req;
  logic [3:0] s_seed_in, s_range, s_rnd;
  logic       s_busy, s_valid;

  lfsr_rand_gen #(
    .WIDTH(4),
    .TAPS (4'hC),
    .SEED (4'h1),
    .STEPS(1),
    .OUT_W(4)
  ) dut_s (
    .clock    (clock),
    .reset    (s_reset),
    .enable   (s_enable),
    .seed_load(s_seed_load),
    .seed_in  (s_seed_in),
    .req      (s_req),
    .range_max(s_range),
    .busy     (s_busy),
    .valid    (s_valid),
    .rnd      (s_rnd)
  );

  // Default instance
  logic        d_reset, d_enable, d_seed_load, d_req;
  logic [15:0] d_seed_in;
  logic [7:0]  d_range, d_rnd;
  logic        d_busy, d_valid;

  lfsr_rand_gen dut_d (
    .clock    (clock),
    .reset    (d_reset),
    .enable   (d_enable),
    .seed_load(d_seed_load),
    .seed_in  (d_seed_in),
    .req      (d_req),
    .range_max(d_range),
    .busy     (d_busy),
    .valid    (d_valid),
    .rnd      (d_rnd)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Hand-derived sequence of the 4-bit LFSR (taps 3,2) starting from 0001.
  localparam logic [3:0] SEQ4 [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                       4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8,
                                       4'h1};

  typedef struct {
    logic [7:0]  rnd;
    int unsigned lat;
  } exp_t;

  exp_t       sbq [$];
  logic [3:0] sq4 [$];
  logic [15:0] md;        // reference LFSR state of the default instance
  logic [7:0]  last_rnd;  // reference of the value rnd should be holding

  function automatic logic [15:0] adv16(input logic [15:0] s, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) s = {s[14:0], ^(s & 16'hB400)};
    return s;
  endfunction

  // Issue one request on the default instance, wait for valid, check value and latency.
  task automatic run_one_d(input logic [7:0] range_v, input string name);
    exp_t e;
    int unsigned cyc;
    bit got;
    logic [7:0] v;
    md = adv16(md, 16);
    v = md[7:0];
    e.lat = 17;
    if (range_v != 0) begin
      e.lat = 17 + v / (range_v + 1);
      v = v % (range_v + 1);
    end
    e.rnd = v;
    sbq.push_back(e);
    d_range = range_v;
    d_req = 1'b1;
    cyc = 0;
    got = 0;
    while (cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) d_req = 1'b0;
      if (d_valid) begin got = 1; break; end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s_timeout: no valid in %0d cycles", name, cyc);
      void'(sbq.pop_front());
      return;
    end
    e = sbq.pop_front();
    n_cmp++;
    if (d_rnd !== e.rnd) begin
      n_bad++;
      $display("FAIL %s_rnd: got %h want %h", name, d_rnd, e.rnd);
    end
    n_cmp++;
    if ((cyc - 1) !== e.lat) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, cyc - 1, e.lat);
    end
    last_rnd = e.rnd;
  endtask

  task automatic test_reset();
    s_enable = 0; s_seed_load = 0; s_seed_in = '0; s_req = 0; s_range = '0;
    d_enable = 0; d_seed_load = 0; d_seed_in = '0; d_req = 0; d_range = '0;
    s_reset = 1; d_reset = 1;
    repeat (2) @(negedge clock);
    n_cmp++; if (s_busy !== 1'b0)  begin n_bad++; $display("FAIL reset_s_busy: got %b want 0", s_busy); end
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid: got %b want 0", s_valid); end
    n_cmp++; if (s_rnd !== 4'h0)   begin n_bad++; $display("FAIL reset_s_rnd: got %h want 0", s_rnd); end
    n_cmp++; if (dut_s.state_q !== 4'h1) begin n_bad++; $display("FAIL reset_s_state: got %h want 1", dut_s.state_q); end
    n_cmp++; if (d_busy !== 1'b0)  begin n_bad++; $display("FAIL reset_d_busy: got %b want 0", d_busy); end
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL reset_d_valid: got %b want 0", d_valid); end
    n_cmp++; if (d_rnd !== 8'h00)  begin n_bad++; $display("FAIL reset_d_rnd: got %h want 00", d_rnd); end
    n_cmp++; if (dut_d.state_q !== 16'h0001) begin n_bad++; $display("FAIL reset_d_state: got %h want 0001", dut_d.state_q); end
    s_reset = 0; d_reset = 0;
    md = 16'h0001;
    last_rnd = 8'h00;
    @(negedge clock);
  endtask

  task automatic test_small_sequence();
    int unsigned cyc;
    bit got;
    logic [15:0] seen;
    logic [3:0] e;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      sq4.push_back(SEQ4[i]);
      s_req = 1'b1;
      cyc = 0;
      got = 0;
      while (cyc < 10) begin
        @(negedge clock);
        cyc++;
        if (cyc == 1) s_req = 1'b0;
        if (s_valid) begin got = 1; break; end
      end
      n_cmp++;
      if (!got) begin
        n_bad++;
        $display("FAIL seq4_timeout: request %0d no valid", i);
        return;
      end
      e = sq4.pop_front();
      n_cmp++; if (s_rnd !== e) begin n_bad++; $display("FAIL seq4_rnd[%0d]: got %b want %b", i, s_rnd, e); end
      n_cmp++; if ((cyc - 1) !== 2) begin n_bad++; $display("FAIL seq4_latency[%0d]: got %0d want 2", i, cyc - 1); end
      seen[s_rnd] = 1'b1;
    end
    n_cmp++;
    if ($countones(seen) !== 15) begin
      n_bad++;
      $display("FAIL seq4_distinct: got %0d distinct want 15", $countones(seen));
    end
  endtask

  task automatic test_small_freerun();
    bit saw_valid;
    logic [3:0] frozen;
    saw_valid = 0;
    s_enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (s_valid) saw_valid = 1;
      if (i == 7) begin
        n_cmp++;
        if (dut_s.state_q !== 4'hA) begin n_bad++; $display("FAIL freerun_mid: got %h want a", dut_s.state_q); end
      end
    end
    s_enable = 1'b0;
    n_cmp++;
    if (dut_s.state_q !== 4'h1) begin n_bad++; $display("FAIL freerun_period: got %h want 1", dut_s.state_q); end
    frozen = 4'h1;
    repeat (20) begin
      @(negedge clock);
      if (s_valid) saw_valid = 1;
    end
    n_cmp++;
    if (dut_s.state_q !== frozen) begin n_bad++; $display("FAIL freerun_frozen: got %h want %h", dut_s.state_q, frozen); end
    n_cmp++;
    if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL freerun_valid: got %b want 0", saw_valid); end
  endtask

  task automatic test_back_to_back();
    int unsigned hist [10];
    int unsigned cyc;
    bit got;
    exp_t e;
    logic [7:0] v;
    for (int i = 0; i < 10; i++) hist[i] = 0;
    d_range = 8'd9;
    d_req = 1'b1;
    for (int n = 0; n < 500; n++) begin
      md = adv16(md, 16);
      v = md[7:0];
      e.rnd = v % 10;
      e.lat = 17 + v / 10;
      sbq.push_back(e);
      cyc = 0;
      got = 0;
      while (cyc < 100) begin
        @(negedge clock);
        cyc++;
        if (cyc == 1) begin
          n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_after_accept[%0d]: got %b want 1", n, d_busy); end
          n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_width[%0d]: got %b want 0", n, d_valid); end
        end
        if (d_valid) begin
          got = 1;
          if (n == 499) d_req = 1'b0;
          break;
        end
      end
      n_cmp++;
      if (!got) begin
        n_bad++;
        $display("FAIL b2b_timeout: request %0d no valid", n);
        d_req = 1'b0;
        return;
      end
      e = sbq.pop_front();
      n_cmp++; if (d_rnd !== e.rnd) begin n_bad++; $display("FAIL b2b_rnd[%0d]: got %0d want %0d", n, d_rnd, e.rnd); end
      n_cmp++; if ((cyc - 1) !== e.lat) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", n, cyc - 1, e.lat); end
      n_cmp++; if (!(d_rnd <= 8'd9)) begin n_bad++; $display("FAIL b2b_range[%0d]: got %0d want <=9", n, d_rnd); end
      n_cmp++; if (!((cyc - 1) <= 42)) begin n_bad++; $display("FAIL b2b_kbound[%0d]: got %0d want <=42", n, cyc - 1); end
      n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_valid[%0d]: got %b want 0", n, d_busy); end
      if (d_rnd < 10) hist[d_rnd]++;
      last_rnd = e.rnd;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (hist[i] == 0) begin n_bad++; $display("FAIL b2b_coverage: value %0d count 0 want >0", i); end
    end
    @(negedge clock);
    n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_release: busy %b want 0", d_busy); end
  endtask

  task automatic test_seed();
    bit saw_valid;
    d_seed_in = 16'h0000;
    d_seed_load = 1'b1;
    @(negedge clock);
    d_seed_load = 1'b0;
    n_cmp++; if (dut_d.state_q !== 16'h0001) begin n_bad++; $display("FAIL seed_zero_guard: got %h want 0001", dut_d.state_q); end
    md = 16'h0001;
    d_range = 8'd0;
    d_req = 1'b1;
    @(negedge clock);
    d_req = 1'b0;
    repeat (4) @(negedge clock);
    d_seed_in = 16'hACE1;
    d_seed_load = 1'b1;
    @(negedge clock);
    d_seed_load = 1'b0;
    d_seed_in = 16'h0000;
    n_cmp++; if (d_busy !== 1'b0)  begin n_bad++; $display("FAIL seed_abort_busy: got %b want 0", d_busy); end
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL seed_abort_valid: got %b want 0", d_valid); end
    n_cmp++; if (d_rnd !== last_rnd) begin n_bad++; $display("FAIL seed_abort_rnd: got %h want %h", d_rnd, last_rnd); end
    n_cmp++; if (dut_d.state_q !== 16'hACE1) begin n_bad++; $display("FAIL seed_load_state: got %h want ace1", dut_d.state_q); end
    md = 16'hACE1;
    saw_valid = 0;
    repeat (40) begin
      @(negedge clock);
      if (d_valid) saw_valid = 1;
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL seed_abort_late_valid: got %b want 0", saw_valid); end
    run_one_d(8'd0, "seed_next");
  endtask

  task automatic test_reset_mid_request();
    bit saw_valid;
    d_range = 8'd0;
    d_req = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clock);
      if (cyc == 1) d_req = 1'b0;
    end
    n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_reduce: busy %b want 1", d_busy); end
    d_reset = 1'b1;
    #1;
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", d_valid); end
    n_cmp++; if (d_busy !== 1'b0)  begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", d_busy); end
    n_cmp++; if (d_rnd !== 8'h00)  begin n_bad++; $display("FAIL rstmid_rnd: got %h want 00", d_rnd); end
    n_cmp++; if (dut_d.state_q !== 16'h0001) begin n_bad++; $display("FAIL rstmid_state: got %h want 0001", dut_d.state_q); end
    @(negedge clock);
    d_reset = 1'b0;
    saw_valid = 0;
    repeat (30) begin
      @(negedge clock);
      if (d_valid) saw_valid = 1;
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_valid: got %b want 0", saw_valid); end
    md = 16'h0001;
    run_one_d(8'd0, "rstmid_first");
  endtask

  task automatic test_req_with_seed();
    bit saw_valid, saw_busy;
    d_range = 8'd0;
    d_seed_in = 16'h1234;
    d_req = 1'b1;
    d_seed_load = 1'b1;
    @(negedge clock);
    d_req = 1'b0;
    d_seed_load = 1'b0;
    d_seed_in = 16'h0000;
    n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL reqseed_busy: got %b want 0", d_busy); end
    n_cmp++; if (dut_d.state_q !== 16'h1234) begin n_bad++; $display("FAIL reqseed_state: got %h want 1234", dut_d.state_q); end
    saw_valid = 0;
    saw_busy = 0;
    repeat (316) begin
      @(negedge clock);
      if (d_valid) saw_valid = 1;
      if (d_busy) saw_busy = 1;
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL reqseed_valid: got %b want 0", saw_valid); end
    n_cmp++; if (saw_busy !== 1'b0)  begin n_bad++; $display("FAIL reqseed_busy_later: got %b want 0", saw_busy); end
    n_cmp++; if (dut_d.state_q !== 16'h1234) begin n_bad++; $display("FAIL reqseed_state_hold: got %h want 1234", dut_d.state_q); end
    md = 16'h1234;
    run_one_d(8'd0, "reqseed_next");
  endtask

  initial begin
    test_reset();
    test_small_sequence();
    test_small_freerun();
    test_back_to_back();
    test_seed();
    test_reset_mid_request();
    test_req_with_seed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
